// File: rtl/round_timer_if.sv
// Bundles the round timer's control inputs and status outputs.
//   master: drives start/check/correct/abort, observes status (testbench or game logic)
//   slave : the timer controller itself
// Signals:
//   start, check, correct, abort   control levels into the timer
//   busy, time_left, timer_tens,   round status out of the timer
//   timer_ones, flash, won,
//   timeout, result_win
interface round_timer_if;
  logic       start;
  logic       check;
  logic       correct;
  logic       abort;
  logic       busy;
  logic [4:0] time_left;
  logic [3:0] timer_tens;
  logic [3:0] timer_ones;
  logic       flash;
  logic       won;
  logic       timeout;
  logic       result_win;

  modport master (
    output start, check, correct, abort,
    input  busy, time_left, timer_tens, timer_ones, flash, won, timeout, result_win
  );

  modport slave (
    input  start, check, correct, abort,
    output busy, time_left, timer_tens, timer_ones, flash, won, timeout, result_win
  );
endinterface

// File: rtl/round_timer_ctrl.sv
// Round timer for a timed quiz game. A start edge opens a round of ROUND_SECS seconds that
// counts down once per TICKS_PER_SEC cycles. A check edge with correct=1 wins the round; with
// correct=0 it costs PENALTY_SECS. Reaching zero ends the round with a timeout. An LED flash
// strobe speeds up as the remaining time shrinks.
// Ports:
//   clk     single clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     round_timer_if.slave:
//             start/check   levels, acted on at 0->1 transitions
//             correct       answer compare, sampled with the check edge
//             abort         returns to idle
//             busy          high while a round runs
//             time_left     remaining seconds; timer_tens/timer_ones are its decimal digits
//             flash         LED strobe, only during a round
//             won/timeout   one-cycle end-of-round pulses
//             result_win    outcome of the last completed round
module round_timer_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned ROUND_SECS    = 20,
  parameter int unsigned PENALTY_SECS  = 2,
  parameter int unsigned FLASH_ON      = 10000000
) (
  input logic         clk,
  input logic         resetn,
  round_timer_if.slave bus
);

  localparam int unsigned PreW = $clog2(TICKS_PER_SEC);
  localparam int unsigned FlW  = $clog2(2 * TICKS_PER_SEC);

  localparam logic [PreW-1:0] PreLast   = PreW'(TICKS_PER_SEC - 1);
  localparam logic [FlW-1:0]  PerSlow   = FlW'(2 * TICKS_PER_SEC - 1);
  localparam logic [FlW-1:0]  PerMid    = FlW'(TICKS_PER_SEC - 1);
  localparam logic [FlW-1:0]  PerFast   = FlW'(TICKS_PER_SEC / 2 - 1);
  localparam logic [FlW-1:0]  FlashOn   = FlW'(FLASH_ON);
  localparam logic [4:0]      RoundSecs = 5'(ROUND_SECS);
  localparam logic [5:0]      Penalty   = 6'(PENALTY_SECS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [4:0]      time_left_q, time_left_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [FlW-1:0]  fl_cnt_q, fl_cnt_d;
  logic [FlW-1:0]  fl_last_q, fl_last_d;
  logic            won_q, won_d;
  logic            timeout_q, timeout_d;
  logic            result_win_q, result_win_d;
  logic            start_q, check_q;
  logic            edge_arm_q;

  logic            start_edge, check_edge;
  logic            terminal, fl_wrap;
  logic [5:0]      dec;

  // Last count of the flash period for a given remaining time.
  function automatic logic [FlW-1:0] period_last(input logic [4:0] t);
    if (t >= 5'd20) begin
      return PerSlow;
    end else if (t >= 5'd10) begin
      return PerMid;
    end else begin
      return PerFast;
    end
  endfunction

  // edge_arm_q masks the first cycle after reset so an input already high at release is
  // absorbed into the edge register instead of reading as a fresh edge.
  assign start_edge = edge_arm_q & bus.start & ~start_q;
  assign check_edge = edge_arm_q & bus.check & ~check_q;
  assign terminal   = (pre_q == PreLast);
  assign fl_wrap    = (fl_cnt_q == fl_last_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      time_left_q  <= 5'd0;
      pre_q        <= '0;
      fl_cnt_q     <= '0;
      fl_last_q    <= '0;
      won_q        <= 1'b0;
      timeout_q    <= 1'b0;
      result_win_q <= 1'b0;
      start_q      <= 1'b0;
      check_q      <= 1'b0;
      edge_arm_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      time_left_q  <= time_left_d;
      pre_q        <= pre_d;
      fl_cnt_q     <= fl_cnt_d;
      fl_last_q    <= fl_last_d;
      won_q        <= won_d;
      timeout_q    <= timeout_d;
      result_win_q <= result_win_d;
      start_q      <= bus.start;
      check_q      <= bus.check;
      edge_arm_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    time_left_d  = time_left_q;
    pre_d        = pre_q;
    fl_cnt_d     = fl_cnt_q;
    fl_last_d    = fl_last_q;
    won_d        = 1'b0;
    timeout_d    = 1'b0;
    result_win_d = result_win_q;
    dec          = 6'd0;

    if (bus.abort) begin
      state_d     = StIdle;
      time_left_d = 5'd0;
      pre_d       = '0;
      fl_cnt_d    = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_edge) begin
            state_d      = StRun;
            time_left_d  = RoundSecs;
            pre_d        = '0;
            fl_cnt_d     = '0;
            fl_last_d    = period_last(RoundSecs);
            result_win_d = 1'b0;
          end
        end
        StRun: begin
          pre_d    = terminal ? '0 : pre_q + PreW'(1);
          fl_cnt_d = fl_wrap ? '0 : fl_cnt_q + FlW'(1);
          if (fl_wrap) begin
            fl_last_d = period_last(time_left_q);
          end
          if (check_edge && bus.correct) begin
            // A win on the terminal-count cycle suppresses that second's decrement.
            won_d        = 1'b1;
            result_win_d = 1'b1;
            state_d      = StDone;
          end else begin
            // Penalty and the per-second tick merge into one saturating subtraction.
            dec = (check_edge ? Penalty : 6'd0) + (terminal ? 6'd1 : 6'd0);
            if (dec != 6'd0) begin
              if ({1'b0, time_left_q} <= dec) begin
                time_left_d  = 5'd0;
                timeout_d    = 1'b1;
                result_win_d = 1'b0;
                state_d      = StDone;
              end else begin
                time_left_d = time_left_q - dec[4:0];
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.busy       = (state_q == StRun);
  assign bus.flash      = (state_q == StRun) && (fl_cnt_q < FlashOn);
  assign bus.time_left  = time_left_q;
  assign bus.timer_tens = 4'(time_left_q / 5'd10);
  assign bus.timer_ones = 4'(time_left_q % 5'd10);
  assign bus.won        = won_q;
  assign bus.timeout    = timeout_q;
  assign bus.result_win = result_win_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Self-checking bench for round_timer_ctrl: directed scenarios with literal expectations,
// then randomized stimulus, all compared every cycle against a behavioural round model.
module tb_round_timer_ctrl;

  localparam int T   = 10;
  localparam int RS  = 5;
  localparam int PEN = 2;
  localparam int FON = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  round_timer_if bus_if ();

  round_timer_ctrl #(
    .TICKS_PER_SEC(T),
    .ROUND_SECS   (RS),
    .PENALTY_SECS (PEN),
    .FLASH_ON     (FON)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus_if)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model: round mode, seconds left, and cycles elapsed in the round.
  int m_mode;     // 0 idle, 1 running, 2 finished
  int m_tl;
  int m_run_cyc;  // cycles since round entry
  int m_fl_base;  // run_cyc at which the current flash period began
  int m_fl_per;
  bit m_won, m_to, m_rw;
  bit m_prev_start, m_prev_check, m_armed;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int flash_period(input int t);
    if (t >= 20) return 2 * T;
    if (t >= 10) return T;
    return T / 2;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_tl = 0; m_run_cyc = 0; m_fl_base = 0; m_fl_per = T / 2;
    m_won = 0; m_to = 0; m_rw = 0;
    m_prev_start = 0; m_prev_check = 0; m_armed = 0;
  endtask

  task automatic model_step();
    bit se, ce, tick, wrap;
    int sub, old_tl;
    if (!resetn) begin
      model_reset();
      return;
    end
    se = m_armed && bus_if.start && !m_prev_start;
    ce = m_armed && bus_if.check && !m_prev_check;
    m_prev_start = bus_if.start;
    m_prev_check = bus_if.check;
    m_armed = 1;
    m_won = 0;
    m_to = 0;
    if (bus_if.abort) begin
      m_mode = 0;
      m_tl = 0;
    end else if (m_mode != 1) begin
      if (se) begin
        m_mode = 1; m_tl = RS; m_run_cyc = 0; m_fl_base = 0;
        m_fl_per = flash_period(RS); m_rw = 0;
      end
    end else begin
      tick = (m_run_cyc % T) == T - 1;
      wrap = (m_run_cyc - m_fl_base) == m_fl_per - 1;
      old_tl = m_tl;
      if (wrap) begin
        m_fl_base = m_run_cyc + 1;
        m_fl_per = flash_period(old_tl);
      end
      m_run_cyc++;
      if (ce && bus_if.correct) begin
        m_won = 1; m_rw = 1; m_mode = 2;
      end else begin
        sub = (ce ? PEN : 0) + (tick ? 1 : 0);
        if (sub > 0) begin
          if (m_tl <= sub) begin
            m_tl = 0; m_to = 1; m_rw = 0; m_mode = 2;
          end else begin
            m_tl -= sub;
          end
        end
      end
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(bus_if.busy), int'(m_mode == 1));
      chk("time_left", int'(bus_if.time_left), m_tl);
      chk("tens", int'(bus_if.timer_tens), m_tl / 10);
      chk("ones", int'(bus_if.timer_ones), m_tl % 10);
      chk("flash", int'(bus_if.flash), int'(m_mode == 1 && (m_run_cyc - m_fl_base) < FON));
      chk("won", int'(bus_if.won), int'(m_won));
      chk("timeout", int'(bus_if.timeout), int'(m_to));
      chk("result_win", int'(bus_if.result_win), int'(m_rw));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus_if.busy), 0);
    chk({tag, "_tl"}, int'(bus_if.time_left), 0);
    chk({tag, "_flash"}, int'(bus_if.flash), 0);
    chk({tag, "_won"}, int'(bus_if.won), 0);
    chk({tag, "_timeout"}, int'(bus_if.timeout), 0);
    chk({tag, "_rw"}, int'(bus_if.result_win), 0);
  endtask

  initial begin
    int k, n, fc;
    bus_if.start = 0; bus_if.check = 0; bus_if.correct = 0; bus_if.abort = 0;
    model_reset();
    chk_en = 1;
    repeat (3) cyc();
    all_zero("reset");
    resetn = 1;
    repeat (2) cyc();

    // Full round with no checks: timeout 50 cycles after entry.
    bus_if.start = 1;
    cyc();
    bus_if.start = 0;
    chk("r36_entry_tl", int'(bus_if.time_left), 5);
    chk("r36_entry_busy", int'(bus_if.busy), 1);
    k = -1;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      if (i == 10) chk("r36_tl_at10", int'(bus_if.time_left), 4);
      if (bus_if.timeout) begin
        k = i;
        break;
      end
    end
    chk("r36_timeout_cycle", k, 50);
    chk("r36_rw", int'(bus_if.result_win), 0);
    chk("r36_busy", int'(bus_if.busy), 0);

    // Correct answer at 3 seconds left, then abort from finished keeps result_win.
    bus_if.start = 1;
    cyc();
    bus_if.start = 0;
    n = 0;
    while (m_tl != 3 && n < 40) begin cyc(); n++; end
    chk("r37_reach3", int'(m_tl == 3), 1);
    bus_if.check = 1; bus_if.correct = 1;
    cyc();
    bus_if.check = 0; bus_if.correct = 0;
    chk("r37_won", int'(bus_if.won), 1);
    chk("r37_rw", int'(bus_if.result_win), 1);
    chk("r37_tl", int'(bus_if.time_left), 3);
    chk("r37_tens", int'(bus_if.timer_tens), 0);
    chk("r37_ones", int'(bus_if.timer_ones), 3);
    repeat (12) cyc();
    chk("r37_held", int'(bus_if.time_left), 3);
    chk("r37_won_clr", int'(bus_if.won), 0);
    bus_if.abort = 1;
    cyc();
    bus_if.abort = 0;
    chk("abort_done_tl", int'(bus_if.time_left), 0);
    chk("abort_done_rw", int'(bus_if.result_win), 1);

    // Three wrong checks: 5 -> 3 -> 1 -> 0 with timeout.
    bus_if.start = 1;
    cyc();
    bus_if.start = 0;
    cyc(); cyc();
    bus_if.check = 1;
    cyc();
    chk("r38_tl3", int'(bus_if.time_left), 3);
    bus_if.check = 0; cyc(); bus_if.check = 1;
    cyc();
    chk("r38_tl1", int'(bus_if.time_left), 1);
    bus_if.check = 0; cyc(); bus_if.check = 1;
    cyc();
    bus_if.check = 0;
    chk("r38_tl0", int'(bus_if.time_left), 0);
    chk("r38_timeout", int'(bus_if.timeout), 1);

    // Wrong check landing on the terminal-count cycle at 4 seconds left.
    bus_if.start = 1;
    cyc();
    bus_if.start = 0;
    n = 0;
    while (!(m_mode == 1 && m_tl == 4 && (m_run_cyc % T) == T - 1) && n < 40) begin
      cyc(); n++;
    end
    bus_if.check = 1;
    cyc();
    bus_if.check = 0;
    chk("r39_tl", int'(bus_if.time_left), 1);
    chk("r39_busy", int'(bus_if.busy), 1);
    bus_if.abort = 1; cyc(); bus_if.abort = 0;

    // Check (and start) held high: a single penalty, so timeout exactly at cycle 30.
    bus_if.start = 1;
    cyc(); cyc(); cyc();
    bus_if.check = 1;
    k = -1;
    for (int i = 3; i <= 45; i++) begin
      cyc();
      if (i == 3) chk("r40_tl3", int'(bus_if.time_left), 3);
      if (bus_if.timeout) begin
        k = i;
        break;
      end
    end
    chk("r40_held_timeout", k, 30);
    bus_if.check = 0; bus_if.start = 0;
    cyc();

    // Flash duty in the fast band, then abort at 2 seconds left.
    bus_if.start = 1;
    cyc();
    bus_if.start = 0;
    fc = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.flash) fc++;
      cyc();
    end
    chk("r40_flash_cnt", fc, 4);
    n = 0;
    while (m_tl != 2 && n < 40) begin cyc(); n++; end
    bus_if.abort = 1;
    cyc();
    bus_if.abort = 0;
    all_zero("r41_abort");

    // Reset mid-round acts without a clock edge; start held across release is not an edge.
    bus_if.start = 1;
    cyc();
    bus_if.start = 0;
    repeat (3) cyc();
    #2;
    resetn = 0;
    model_reset();
    #1;
    all_zero("r41_reset");
    chk("r41_reset_ones", int'(bus_if.timer_ones), 0);
    bus_if.start = 1;
    repeat (2) cyc();
    resetn = 1;
    repeat (3) cyc();
    chk("r35_no_edge", int'(bus_if.busy), 0);
    bus_if.start = 0;
    cyc();
    bus_if.start = 1;
    cyc();
    chk("r35_real_edge", int'(bus_if.busy), 1);
    bus_if.start = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus_if.start   = ($urandom_range(0, 7) == 0);
      bus_if.check   = ($urandom_range(0, 5) == 0);
      bus_if.correct = ($urandom_range(0, 3) == 0);
      bus_if.abort   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        resetn = 0;
        model_reset();
        cyc();
        resetn = 1;
      end else begin
        cyc();
      end
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_timer_ctrl.md
ROUND_TIMER_CTRL -- requirements
Module: round_timer_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000, meaning clk cycles per game second (>=4, even).
REQ-002 SHALL have parameter ROUND_SECS, default 20, meaning round length in seconds (1..31).
REQ-003 SHALL have parameter PENALTY_SECS, default 2, meaning seconds removed per wrong check (1..31).
REQ-004 SHALL have parameter FLASH_ON, default 10000000, meaning flash high-time in cycles (< TICKS_PER_SEC/2).
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port resetn, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, level; a rising edge requests a new round.
REQ-008 SHALL have port check, input, 1, level; a rising edge submits the current answer.
REQ-009 SHALL have port correct, input, 1, datapath compare result, sampled on the cycle the check edge is detected.
REQ-010 SHALL have port abort, input, 1, level; forces return to IDLE.
REQ-011 SHALL have port busy, output, 1, high in RUN.
REQ-012 SHALL have port time_left, output, 5, remaining whole seconds.
REQ-013 SHALL have port timer_tens / timer_ones, outputs, 4 each, time_left/10 and time_left%10, combinational.
REQ-014 SHALL have port flash, output, 1, LED flash strobe.
REQ-015 SHALL have port won / timeout, outputs, 1 each, single-cycle end-of-round pulses.
REQ-016 SHALL have port result_win, output, 1, held outcome of the last completed round.

Function
REQ-017 SHALL register start and check and act only on 0->1 edges; holding either high produces exactly one event.
REQ-018 SHALL implement states IDLE, RUN, DONE.
REQ-019 IDLE/DONE + start edge SHALL, next cycle: state=RUN, time_left=ROUND_SECS, prescaler=0, flash counter=0, result_win=0.
REQ-020 RUN SHALL count prescaler 0..TICKS_PER_SEC-1; at terminal count it wraps to 0 and time_left decrements by 1.
REQ-021 A decrement from 1 to 0 SHALL pulse timeout for one cycle, go to DONE with result_win=0.
REQ-022 A check edge in RUN with correct=1 SHALL pulse won, set result_win=1, go to DONE, freeze time_left.
REQ-023 A check edge in RUN with correct=0 SHALL subtract PENALTY_SECS from time_left, saturating at 0; result 0 means timeout per REQ-021; prescaler is not reset.
REQ-024 A check edge coinciding with the prescaler terminal count SHALL take priority: correct=1 means won with no decrement; correct=0 means subtract PENALTY_SECS+1, saturating.
REQ-025 Start and check edges in states where they are not defined SHALL be ignored, including start during RUN.
REQ-026 abort=1 in any state SHALL go to IDLE next cycle, time_left=0, no won/timeout pulse; result_win is kept.
REQ-027 Flash period SHALL be 2*TICKS_PER_SEC if time_left>=20, TICKS_PER_SEC if 10..19, and TICKS_PER_SEC/2 if <10.
REQ-028 The period SHALL be re-selected only when the flash counter wraps.
REQ-029 flash SHALL be 1 while the flash counter < FLASH_ON, and only in RUN; 0 otherwise.
REQ-030 time_left SHALL hold its value in DONE; busy, won and timeout SHALL be 0 outside the conditions above.
REQ-031 Arithmetic SHALL use 5-bit time_left; prescaler and flash counter widths SHALL be sized from the parameters.
REQ-032 No underflow/wrap of time_left SHALL occur.

Reset
REQ-033 resetn=0 SHALL immediately force: state IDLE, time_left=0, counters 0, busy=0, flash=0, won=0, timeout=0, result_win=0, edge registers 0.
REQ-034 Reset mid-RUN SHALL discard the round with no pulses.
REQ-035 After release, a start input already high SHALL NOT count as an edge.

Verification (TICKS_PER_SEC=10, ROUND_SECS=5, PENALTY_SECS=2, FLASH_ON=2)
REQ-036 Start edge, no checks: time_left 5,4,3,2,1 each 10 cycles apart -> timeout pulse 50 cycles after RUN entry, result_win=0, busy=0.
REQ-037 Start, check with correct=1 at time_left=3 -> won pulse next cycle, result_win=1, time_left held 3, tens=0, ones=3.
REQ-038 Start, two wrong checks -> time_left 5->3->1; a third wrong check -> time_left 0, timeout pulse.
REQ-039 Wrong check on the terminal-count cycle at time_left=4 -> time_left=1.
REQ-040 flash in RUN (time_left<10) -> high 2 cycles of every 5; check held high 30 cycles -> one penalty only.
REQ-041 abort at time_left=2 -> IDLE, no pulses; resetn low mid-RUN -> all outputs 0 without a clock edge.
